// File: rtl/accumulator_unit.sv
// Accumulator/product-register unit: single-cycle ALU ops on acc with sticky
// overflow and optional saturation, plus a 16-cycle iterative signed multiplier.
module accumulator_unit #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [2:0]   op,
   input  logic [W-1:0] operand,
   input  logic [15:0]  mul_a,
   input  logic [15:0]  mul_b,
   input  logic         ovm,
   output logic [W-1:0] acc,
   output logic [W-1:0] preg,
   output logic         ov,
   output logic         zero,
   output logic         neg,
   output logic         done
);

   localparam logic [2:0] OP_CLROV = 3'b000;
   localparam logic [2:0] OP_LAC   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_MPY   = 3'b110;
   localparam logic [2:0] OP_APAC  = 3'b111;

   typedef enum logic {IDLE, MUL} state_e;

   state_e       state_q, state_d;
   logic [3:0]   cnt_q;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] preg_q;
   logic [W-1:0] mcand_q;
   logic [W-1:0] partial_q;
   logic [W-1:0] mulTerm;
   logic [15:0]  mplier_q;
   logic         ov_q, ov_d;
   logic         done_q;
   logic         accept;
   logic [W:0]   sum33;
   logic         ovf;

   assign accept = op_valid && op_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && op == OP_MPY) state_d = MUL;
         MUL:     if (cnt_q == 4'd15) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_ready = (state_q == IDLE);
   end

   // ALU result for the request being presented; only committed on accept.
   always_comb begin
      sum33 = '0;
      acc_d = acc_q;
      ov_d  = ov_q;
      case (op)
         OP_ADD:  sum33 = {acc_q[W-1], acc_q} + {operand[W-1], operand};
         OP_SUB:  sum33 = {acc_q[W-1], acc_q} - {operand[W-1], operand};
         OP_APAC: sum33 = {acc_q[W-1], acc_q} + {preg_q[W-1], preg_q};
         default: sum33 = '0;
      endcase
      ovf = sum33[W] ^ sum33[W-1];
      case (op)
         OP_CLROV: ov_d = 1'b0;
         OP_LAC:   acc_d = operand;
         OP_AND:   acc_d = acc_q & operand;
         OP_OR:    acc_d = acc_q | operand;
         OP_ADD, OP_SUB, OP_APAC: begin
            acc_d = sum33[W-1:0];
            if (ovf) begin
               ov_d = 1'b1;
               if (ovm) acc_d = sum33[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
         end
         default: acc_d = acc_q;
      endcase
   end

   // Bit 15 of the multiplier carries negative weight in two's complement.
   always_comb begin
      mulTerm = '0;
      if (mplier_q[cnt_q]) mulTerm = (cnt_q == 4'd15) ? -mcand_q : mcand_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         preg_q    <= '0;
         ov_q      <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= 4'd0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         partial_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            acc_q <= acc_d;
            ov_q  <= ov_d;
            if (op == OP_MPY) begin
               mcand_q   <= {{(W-16){mul_a[15]}}, mul_a};
               mplier_q  <= mul_b;
               partial_q <= '0;
               cnt_q     <= 4'd0;
            end
         end
         if (state_q == MUL) begin
            cnt_q     <= cnt_q + 4'd1;
            mcand_q   <= mcand_q << 1;
            partial_q <= partial_q + mulTerm;
            if (cnt_q == 4'd15) begin
               preg_q <= partial_q + mulTerm;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign acc  = acc_q;
   assign preg = preg_q;
   assign ov   = ov_q;
   assign done = done_q;
   assign zero = (acc_q == '0);
   assign neg  = acc_q[W-1];

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed-vector bench for accumulator_unit; each task drives one scenario
// and checks the outputs against hand-computed values.
module tb_accumulator_unit;

   localparam logic [2:0] OP_CLROV = 3'b000;
   localparam logic [2:0] OP_LAC   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_MPY   = 3'b110;
   localparam logic [2:0] OP_APAC  = 3'b111;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op;
   logic [31:0] operand;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        ovm;
   logic [31:0] acc;
   logic [31:0] preg;
   logic        ov;
   logic        zero;
   logic        neg;
   logic        done;

   int tests = 0;
   int fails = 0;

   accumulator_unit #(.W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op       (op),
      .operand  (operand),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .ovm      (ovm),
      .acc      (acc),
      .preg     (preg),
      .ov       (ov),
      .zero     (zero),
      .neg      (neg),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one request for exactly one edge, then returns at edge+1.
   task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic m);
      op       = o;
      operand  = d;
      ovm      = m;
      op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      tests++; if (acc !== 32'h0) begin fails++; $display("[TB] FAIL reset_acc: got %h expected %h", acc, 32'h0); end
      tests++; if (preg !== 32'h0) begin fails++; $display("[TB] FAIL reset_preg: got %h expected %h", preg, 32'h0); end
      tests++; if ({ov, done, op_ready, zero, neg} !== 5'b00110) begin fails++; $display("[TB] FAIL reset_flags: got %b expected %b", {ov, done, op_ready, zero, neg}, 5'b00110); end
      #15;
      rst_n    = 1'b1;
      op       = OP_LAC;
      operand  = 32'h0000_00A5;
      op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      tests++; if (acc !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL first_accept: got %h expected %h", acc, 32'h0000_00A5); end
   endtask

   task automatic test_logic;
      issue(OP_LAC, 32'h0, 1'b0);
      tests++; if ({zero, neg} !== 2'b10) begin fails++; $display("[TB] FAIL lac0_flags: got %b expected %b", {zero, neg}, 2'b10); end
      issue(OP_LAC, 32'hFFFF_0000, 1'b0);
      issue(OP_OR, 32'h0000_FFFF, 1'b0);
      tests++; if (acc !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL or_acc: got %h expected %h", acc, 32'hFFFF_FFFF); end
      tests++; if ({zero, neg} !== 2'b01) begin fails++; $display("[TB] FAIL or_flags: got %b expected %b", {zero, neg}, 2'b01); end
      issue(OP_AND, 32'h0F0F_1234, 1'b0);
      tests++; if (acc !== 32'h0F0F_1234) begin fails++; $display("[TB] FAIL and_mask: got %h expected %h", acc, 32'h0F0F_1234); end
      issue(OP_AND, 32'h0, 1'b0);
      tests++; if ({zero, acc} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL and0: got zero=%b acc=%h expected zero=1 acc=0", zero, acc); end
   endtask

   task automatic test_back_to_back;
      op       = OP_LAC;
      operand  = 32'd5;
      ovm      = 1'b0;
      op_valid = 1'b1;
      @(posedge clk); #1;
      tests++; if (acc !== 32'd5) begin fails++; $display("[TB] FAIL b2b_lac: got %h expected %h", acc, 32'd5); end
      op = OP_ADD; operand = 32'd10;
      @(posedge clk); #1;
      tests++; if (acc !== 32'd15) begin fails++; $display("[TB] FAIL b2b_add: got %h expected %h", acc, 32'd15); end
      op = OP_SUB; operand = 32'd20;
      @(posedge clk); #1;
      tests++; if ({acc, neg, ov} !== {32'hFFFF_FFFB, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL b2b_sub: got acc=%h neg=%b ov=%b expected acc=fffffffb neg=1 ov=0", acc, neg, ov); end
      op_valid = 1'b0; op = OP_LAC; operand = 32'h0000_0999;
      @(posedge clk); #1;
      tests++; if (acc !== 32'hFFFF_FFFB) begin fails++; $display("[TB] FAIL no_valid_ignored: got %h expected %h", acc, 32'hFFFF_FFFB); end
   endtask

   task automatic test_saturate;
      issue(OP_CLROV, 32'h0, 1'b0);
      issue(OP_LAC, 32'h7FFF_FFF0, 1'b0);
      issue(OP_ADD, 32'h0000_0020, 1'b1);
      tests++; if ({acc, ov} !== {32'h7FFF_FFFF, 1'b1}) begin fails++; $display("[TB] FAIL add_sat: got acc=%h ov=%b expected acc=7fffffff ov=1", acc, ov); end
      issue(OP_CLROV, 32'h0, 1'b0);
      issue(OP_LAC, 32'h7FFF_FFF0, 1'b0);
      issue(OP_ADD, 32'h0000_0020, 1'b0);
      tests++; if ({acc, ov} !== {32'h8000_0010, 1'b1}) begin fails++; $display("[TB] FAIL add_wrap: got acc=%h ov=%b expected acc=80000010 ov=1", acc, ov); end
      issue(OP_ADD, 32'h0000_0001, 1'b0);
      tests++; if ({acc, ov} !== {32'h8000_0011, 1'b1}) begin fails++; $display("[TB] FAIL ov_sticky: got acc=%h ov=%b expected acc=80000011 ov=1", acc, ov); end
   endtask

   task automatic test_sub_clrov;
      issue(OP_CLROV, 32'h0, 1'b0);
      issue(OP_LAC, 32'h8000_0000, 1'b0);
      issue(OP_SUB, 32'h0000_0001, 1'b1);
      tests++; if ({acc, ov} !== {32'h8000_0000, 1'b1}) begin fails++; $display("[TB] FAIL sub_sat: got acc=%h ov=%b expected acc=80000000 ov=1", acc, ov); end
      issue(OP_CLROV, 32'h0, 1'b0);
      tests++; if ({acc, ov} !== {32'h8000_0000, 1'b0}) begin fails++; $display("[TB] FAIL clrov: got acc=%h ov=%b expected acc=80000000 ov=0", acc, ov); end
      issue(OP_SUB, 32'h0000_0001, 1'b0);
      tests++; if ({acc, ov} !== {32'h7FFF_FFFF, 1'b1}) begin fails++; $display("[TB] FAIL sub_wrap: got acc=%h ov=%b expected acc=7fffffff ov=1", acc, ov); end
   endtask

   task automatic test_mpy;
      int cycles;
      int doneCount;
      bit disturbed;
      issue(OP_LAC, 32'h0000_0055, 1'b0);
      op       = OP_MPY;
      mul_a    = 16'hFFFD;
      mul_b    = 16'h0007;
      op_valid = 1'b1;
      @(posedge clk); #1;
      op = OP_LAC; operand = 32'h0000_DEAD; mul_a = 16'h1111; mul_b = 16'h2222;
      cycles = 0; doneCount = 0; disturbed = 1'b0;
      while (!op_ready && cycles < 40) begin
         cycles++;
         if (acc !== 32'h0000_0055 || preg !== 32'h0) disturbed = 1'b1;
         if (done) doneCount++;
         @(posedge clk); #1;
      end
      tests++; if (cycles !== 16) begin fails++; $display("[TB] FAIL mpy_busy_cycles: got %0d expected %0d", cycles, 16); end
      tests++; if (disturbed !== 1'b0) begin fails++; $display("[TB] FAIL mpy_held_state: got %b expected %b", disturbed, 1'b0); end
      tests++; if ({doneCount, done} !== {32'd0, 1'b1}) begin fails++; $display("[TB] FAIL mpy_done_pulse: got early=%0d done=%b expected early=0 done=1", doneCount, done); end
      tests++; if (preg !== 32'hFFFF_FFEB) begin fails++; $display("[TB] FAIL mpy_preg: got %h expected %h", preg, 32'hFFFF_FFEB); end
      @(posedge clk); #1;
      op_valid = 1'b0;
      tests++; if ({done, acc} !== {1'b0, 32'h0000_DEAD}) begin fails++; $display("[TB] FAIL held_req_after_mul: got done=%b acc=%h expected done=0 acc=0000dead", done, acc); end
   endtask

   task automatic test_mpy_apac;
      int cycles;
      issue(OP_CLROV, 32'h0, 1'b0);
      issue(OP_LAC, 32'h0, 1'b0);
      op       = OP_MPY;
      mul_a    = 16'h8000;
      mul_b    = 16'h8000;
      op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      cycles = 0;
      while (!done && cycles < 40) begin
         cycles++;
         @(posedge clk); #1;
      end
      tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL mpy2_done_timeout: got %b expected %b", done, 1'b1); end
      issue(OP_APAC, 32'h0, 1'b0);
      tests++; if (preg !== 32'h4000_0000) begin fails++; $display("[TB] FAIL mpy2_preg: got %h expected %h", preg, 32'h4000_0000); end
      tests++; if ({acc, ov} !== {32'h4000_0000, 1'b0}) begin fails++; $display("[TB] FAIL apac: got acc=%h ov=%b expected acc=40000000 ov=0", acc, ov); end
   endtask

   task automatic test_reset_in_mul;
      bit sawDone;
      issue(OP_LAC, 32'h0000_1234, 1'b0);
      mul_a = 16'h0005;
      mul_b = 16'h0005;
      issue(OP_MPY, 32'h0, 1'b0);
      repeat (7) begin @(posedge clk); #1; end
      tests++; if (op_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_mul_busy: got %b expected %b", op_ready, 1'b0); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if ({acc, preg} !== {32'h0, 32'h0}) begin fails++; $display("[TB] FAIL abort_regs: got acc=%h preg=%h expected 0 0", acc, preg); end
      tests++; if ({op_ready, done, ov} !== 3'b100) begin fails++; $display("[TB] FAIL abort_flags: got %b expected %b", {op_ready, done, ov}, 3'b100); end
      #1 rst_n = 1'b1;
      sawDone = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) sawDone = 1'b1;
      end
      tests++; if ({sawDone, preg} !== {1'b0, 32'h0}) begin fails++; $display("[TB] FAIL abort_no_done: got done_seen=%b preg=%h expected 0 0", sawDone, preg); end
   endtask

   initial begin
      rst_n    = 1'b1;
      op_valid = 1'b0;
      op       = OP_CLROV;
      operand  = 32'h0;
      mul_a    = 16'h0;
      mul_b    = 16'h0;
      ovm      = 1'b0;
      #1 rst_n = 1'b0;
      test_reset();
      test_logic();
      test_back_to_back();
      test_saturate();
      test_sub_clrov();
      test_mpy();
      test_mpy_apac();
      test_reset_in_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
